ui_layer_compositor: RTL

Parametrised pixel compositor that replaces the fixed sky/grass/dirt/qbox/flag/player/status priority chain in the game renderer. It merges N layer (enable, colour) pairs plus a background colour by index priority through a configurable register pipeline. It also alpha-blends a full-screen overlay (finish screen) that fades in and out on frame boundaries. It sits between the per-object renderers and the VGA output registers.

---
 rtl/ui_layer_compositor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ui_layer_compositor.sv
// ui_layer_compositor: index-priority merge of N_LAYERS layers over bg_rgb, then an alpha-blended
// full-screen overlay. Define UI_COMP_FADE_EN to enable the frame-stepped fade in/out FSM.
module ui_layer_compositor #(
    parameter int N_LAYERS         = 12,
    parameter int PIPE             = 2,
    parameter int FADE_STEP_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_LAYERS-1:0]     layer_en,
    input  logic [N_LAYERS*24-1:0]  layer_rgb,
    input  logic [23:0]             bg_rgb,
    input  logic                    overlay_en,
    input  logic [23:0]             overlay_rgb,
    input  logic                    overlay_req,
    input  logic                    frame_start,
    output logic [7:0]              r,
    output logic [7:0]              g,
    output logic [7:0]              b,
    output logic                    overlay_pixel_en,
    output logic [4:0]              top_layer,
    output logic                    fade_done
);

    typedef struct packed {
        logic [23:0] base;
        logic [4:0]  top;
        logic        ov_en;
        logic [23:0] ov;
        logic [4:0]  alpha;
    } pix_t;

    localparam logic [4:0] ALPHA_FULL = 5'd16;

    logic [4:0] alpha_q;
    pix_t       sel_p0;
    pix_t       fin_p;
    logic       fin_vld;

    if (N_LAYERS < 2 || N_LAYERS > 16 || PIPE < 1 || PIPE > 4 ||
        FADE_STEP_FRAMES < 1 || FADE_STEP_FRAMES > 15) begin : g_bad_param
        $error("ui_layer_compositor: parameter out of range");
    end

    function automatic logic [7:0] blend_ch(input logic [7:0] ov, input logic [7:0] base,
                                            input logic [4:0] alpha);
        logic [12:0] acc;
        acc = 13'(ov) * 13'(alpha) + 13'(base) * (13'd16 - 13'(alpha));
        return 8'(acc >> 4);
    endfunction

    function automatic logic [23:0] blend_px(input pix_t p);
        if (!p.ov_en)
            return p.base;
        return {blend_ch(p.ov[23:16], p.base[23:16], p.alpha),
                blend_ch(p.ov[15:8],  p.base[15:8],  p.alpha),
                blend_ch(p.ov[7:0],   p.base[7:0],   p.alpha)};
    endfunction

    // Stage 1 select: later (higher) indices overwrite earlier ones.
    always_comb begin
        sel_p0.base  = bg_rgb;
        sel_p0.top   = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer_en[i]) begin
                sel_p0.base = layer_rgb[24*i +: 24];
                sel_p0.top  = 5'(i + 1);
            end
        end
        sel_p0.ov_en = overlay_en;
        sel_p0.ov    = overlay_rgb;
        sel_p0.alpha = alpha_q;
    end

    if (PIPE == 1) begin : g_direct
        assign fin_p   = sel_p0;
        assign fin_vld = 1'b1;
    end else begin : g_stages
        pix_t            pix_pipe [PIPE-1];
        logic [PIPE-2:0] vld_pipe;

        always_ff @(posedge clk) begin
            pix_pipe[0] <= sel_p0;
            for (int k = 1; k < PIPE - 1; k++)
                pix_pipe[k] <= pix_pipe[k-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= 1'b1;
                for (int k = 1; k < PIPE - 1; k++)
                    vld_pipe[k] <= vld_pipe[k-1];
            end
        end

        assign fin_p   = pix_pipe[PIPE-2];
        assign fin_vld = vld_pipe[PIPE-2];
    end

    // Last stage: blend and register outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r                <= '0;
            g                <= '0;
            b                <= '0;
            overlay_pixel_en <= 1'b0;
            top_layer        <= '0;
        end else if (fin_vld) begin
            {r, g, b}        <= blend_px(fin_p);
            overlay_pixel_en <= fin_p.ov_en && (fin_p.alpha != '0);
            top_layer        <= fin_p.top;
        end
    end

`ifdef UI_COMP_FADE_EN
    typedef enum logic [1:0] {IDLE, FADE_IN, SHOWN, FADE_OUT} state_t;

    state_t     state_q;
    logic [3:0] step_cnt_q;
    logic       step_hit;

    assign step_hit = (step_cnt_q == 4'(FADE_STEP_FRAMES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            alpha_q    <= '0;
            step_cnt_q <= '0;
            fade_done  <= 1'b0;
        end else if (frame_start) begin
            case (state_q)
                IDLE: begin
                    if (overlay_req) begin
                        state_q    <= FADE_IN;
                        step_cnt_q <= '0;
                    end
                end
                FADE_IN: begin
                    if (!overlay_req) begin
                        state_q    <= FADE_OUT;
                        step_cnt_q <= '0;
                    end else if (step_hit) begin
                        step_cnt_q <= '0;
                        if (alpha_q >= 5'd14) begin
                            alpha_q   <= ALPHA_FULL;
                            state_q   <= SHOWN;
                            fade_done <= 1'b1;
                        end else begin
                            alpha_q <= alpha_q + 5'd2;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 4'd1;
                    end
                end
                SHOWN: begin
                    if (!overlay_req) begin
                        state_q    <= FADE_OUT;
                        step_cnt_q <= '0;
                        fade_done  <= 1'b0;
                    end
                end
                FADE_OUT: begin
                    if (overlay_req) begin
                        state_q    <= FADE_IN;
                        step_cnt_q <= '0;
                    end else if (step_hit) begin
                        step_cnt_q <= '0;
                        if (alpha_q <= 5'd2) begin
                            alpha_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            alpha_q <= alpha_q - 5'd2;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    // No fade: overlay snaps fully on or off at each frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alpha_q   <= '0;
            fade_done <= 1'b0;
        end else if (frame_start) begin
            alpha_q   <= overlay_req ? ALPHA_FULL : 5'd0;
            fade_done <= overlay_req;
        end
    end
`endif

endmodule
